// File: rtl/fifo_read_ctrl_pkg.sv
// Shared types and constants for the FIFO read-side controller and its ring buffer.
package fifo_read_ctrl_pkg;

    localparam int BUF_DEPTH = 4;
    localparam int PTR_W     = 2;
    localparam int OCC_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Read-side bundle: FIFO flags/data, read strobe and the downstream valid/ready channel.
interface fifo_read_ctrl_if #(
    parameter int WORD_SIZE = 10
);
    logic                 rd_en;
    logic                 fifo_empty;
    logic                 fifo_error;
    logic [WORD_SIZE-1:0] fifo_data;
    logic                 fifo_rd;
    logic [WORD_SIZE-1:0] data_out;
    logic                 valid_out;
    logic                 ready_in;
    logic                 err_clr;
    logic                 reader_err;

    // The controller is the slave; the FIFO/consumer environment is the master.
    modport slave (
        input  rd_en, fifo_empty, fifo_error, fifo_data, ready_in, err_clr,
        output fifo_rd, data_out, valid_out, reader_err
    );

    modport master (
        output rd_en, fifo_empty, fifo_error, fifo_data, ready_in, err_clr,
        input  fifo_rd, data_out, valid_out, reader_err
    );
endinterface

// File: rtl/read_ring_buf.sv
// Four-entry ring buffer holding words returned by the FIFO until the consumer pops them.
module read_ring_buf
    import fifo_read_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 capture,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 ready,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 valid,
    output logic                 pop,
    output logic [OCC_W-1:0]     occ,
    output logic [OCC_W-1:0]     occ_next
);
    logic [WORD_SIZE-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    assign valid    = (occ != '0);
    assign pop      = valid & ready;
    assign rd_data  = mem[rd_ptr];
    assign occ_next = occ + OCC_W'(capture) - OCC_W'(pop);

    // NOTE: the storage is reset as well so data_out reads 0 after reset instead of stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (capture) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ_next;
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// FIFO read-side controller: issues fifo_rd, runs the IDLE/RUN/STALL/FAULT FSM.
// Define FIFO_READ_CTRL_STATS_EN to add the saturating rd_count pop counter.
module fifo_read_ctrl
    import fifo_read_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 10
`ifdef FIFO_READ_CTRL_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    fifo_read_ctrl_if.slave  bus
`ifdef FIFO_READ_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] rd_count
`endif
);
    state_t           state_q;
    state_t           state_d;
    logic             inflight;
    logic             fifo_rd;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;

    read_ring_buf #(
        .WORD_SIZE (WORD_SIZE)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .capture  (inflight),
        .wr_data  (bus.fifo_data),
        .ready    (bus.ready_in),
        .rd_data  (bus.data_out),
        .valid    (bus.valid_out),
        .pop      (pop),
        .occ      (occ),
        .occ_next (occ_next)
    );

    // Counting the in-flight word guarantees its slot exists when it returns; no ready_in term.
    assign fifo_rd = bus.rd_en & ~bus.fifo_empty & ~reset & (state_q != FAULT)
                   & ((occ + OCC_W'(inflight)) < OCC_W'(BUF_DEPTH));

    assign bus.fifo_rd    = fifo_rd;
    assign bus.reader_err = (state_q == FAULT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            inflight <= 1'b0;
        end else begin
            state_q  <= state_d;
            inflight <= fifo_rd;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fifo_rd) state_d = RUN;
            end
            RUN: begin
                if (occ_next == OCC_W'(BUF_DEPTH)) state_d = STALL;
                else if (occ_next == '0 && !fifo_rd) state_d = IDLE;
            end
            STALL: begin
                if (pop) state_d = RUN;
            end
            FAULT: begin
                if (bus.err_clr) state_d = (occ_next == '0) ? IDLE : RUN;
            end
            default: state_d = IDLE;
        endcase
        // A new error wins over everything, including a same-cycle err_clr.
        if (bus.fifo_error) state_d = FAULT;
    end

`ifdef FIFO_READ_CTRL_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
        end else if (pop && (rd_count != {CNT_W{1'b1}})) begin
            rd_count <= rd_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed testbench for fifo_read_ctrl with a behavioural FIFO model and a pop monitor.
module tb_fifo_read_ctrl;
    import fifo_read_ctrl_pkg::*;

    localparam int W = 10;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fifo_read_ctrl_if #(.WORD_SIZE(W)) bus ();

`ifdef FIFO_READ_CTRL_STATS_EN
    logic [15:0] rd_count;
    fifo_read_ctrl #(.WORD_SIZE(W), .CNT_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .rd_count (rd_count)
    );
`else
    fifo_read_ctrl #(.WORD_SIZE(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: words pushed by the tests, data returned the cycle after fifo_rd.
    logic [W-1:0] fifo_mem [0:63];
    int           fifo_head;
    int           fifo_tail;
    assign bus.fifo_empty = (fifo_head == fifo_tail);

    always @(posedge clk) begin
        if (bus.fifo_rd) begin
            bus.fifo_data <= fifo_mem[fifo_head];
            fifo_head     <= fifo_head + 1;
        end
    end

    // Monitor: counts read strobes and records every word accepted by the consumer.
    int           rd_pulses;
    int           n_got;
    logic [W-1:0] got [0:63];

    always @(posedge clk) begin
        if (bus.fifo_rd) rd_pulses <= rd_pulses + 1;
        if (bus.valid_out && bus.ready_in) begin
            got[n_got] <= bus.data_out;
            n_got      <= n_got + 1;
        end
    end

    task automatic push(input logic [W-1:0] w);
        fifo_mem[fifo_tail] = w;
        fifo_tail = fifo_tail + 1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.rd_en      = 1'b1;
        bus.ready_in   = 1'b0;
        bus.fifo_error = 1'b0;
        bus.err_clr    = 1'b0;
        push(10'h3FF);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.fifo_rd !== 1'b0) begin failures++; $display("FAIL rst_fifo_rd: got %b expected 0", bus.fifo_rd); end
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", bus.valid_out); end
        checks++; if (bus.data_out !== 10'h000) begin failures++; $display("FAIL rst_data: got %h expected 000", bus.data_out); end
        checks++; if (bus.reader_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", bus.reader_err); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL rst_state: got %0d expected %0d", dut.state_q, IDLE); end
        checks++; if (dut.occ !== 3'd0) begin failures++; $display("FAIL rst_occ: got %0d expected 0", dut.occ); end
`ifdef FIFO_READ_CTRL_STATS_EN
        checks++; if (rd_count !== 16'd0) begin failures++; $display("FAIL rst_count: got %0d expected 0", rd_count); end
`endif
        fifo_tail = fifo_head;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int base_rd;
        int base_got;
        base_rd  = rd_pulses;
        base_got = n_got;
        bus.ready_in = 1'b1;
        push(10'h155);
        #1;
        checks++; if (bus.fifo_rd !== 1'b1) begin failures++; $display("FAIL single_rd_issue: got %b expected 1", bus.fifo_rd); end
        @(negedge clk);
        checks++; if (bus.fifo_rd !== 1'b0) begin failures++; $display("FAIL single_rd_one_shot: got %b expected 0", bus.fifo_rd); end
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL single_valid_early: got %b expected 0", bus.valid_out); end
        @(negedge clk);
        checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL single_valid: got %b expected 1", bus.valid_out); end
        checks++; if (bus.data_out !== 10'h155) begin failures++; $display("FAIL single_data: got %h expected 155", bus.data_out); end
        @(negedge clk);
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL single_valid_drop: got %b expected 0", bus.valid_out); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL single_idle: got %0d expected %0d", dut.state_q, IDLE); end
        checks++; if (rd_pulses - base_rd != 1) begin failures++; $display("FAIL single_pulses: got %0d expected 1", rd_pulses - base_rd); end
        checks++; if (n_got - base_got != 1) begin failures++; $display("FAIL single_count: got %0d expected 1", n_got - base_got); end
    endtask

    task automatic test_back_pressure();
        int base_rd;
        int base_got;
        int ncyc;
        base_rd  = rd_pulses;
        base_got = n_got;
        bus.ready_in = 1'b0;
        for (int i = 0; i < 6; i++) push(10'(10'h101 + i));
        repeat (8) @(negedge clk);
        checks++; if (rd_pulses - base_rd != 4) begin failures++; $display("FAIL bp_pulses: got %0d expected 4", rd_pulses - base_rd); end
        checks++; if (dut.state_q !== STALL) begin failures++; $display("FAIL bp_stall: got %0d expected %0d", dut.state_q, STALL); end
        checks++; if (dut.occ !== 3'd4) begin failures++; $display("FAIL bp_occ: got %0d expected 4", dut.occ); end
        checks++; if (bus.fifo_rd !== 1'b0) begin failures++; $display("FAIL bp_rd_low: got %b expected 0", bus.fifo_rd); end
        checks++; if (bus.data_out !== 10'h101) begin failures++; $display("FAIL bp_head: got %h expected 101", bus.data_out); end
        bus.ready_in = 1'b1;
        ncyc = 0;
        for (int c = 0; c < 20 && (n_got - base_got) < 6; c++) begin
            @(negedge clk);
            ncyc++;
        end
        checks++; if (n_got - base_got != 6) begin failures++; $display("FAIL bp_count: got %0d expected 6", n_got - base_got); end
        checks++; if (ncyc != 6) begin failures++; $display("FAIL bp_rate: got %0d cycles expected 6", ncyc); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[base_got + i] !== 10'(10'h101 + i)) begin
                failures++;
                $display("FAIL bp_word%0d: got %h expected %h", i, got[base_got + i], 10'(10'h101 + i));
            end
        end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL bp_idle: got %0d expected %0d", dut.state_q, IDLE); end
        checks++; if (rd_pulses - base_rd != 6) begin failures++; $display("FAIL bp_total_pulses: got %0d expected 6", rd_pulses - base_rd); end
    endtask

    task automatic test_wrap();
        int           base_got;
        logic         hold;
        logic [W-1:0] held;
        base_got = n_got;
        for (int i = 0; i < 9; i++) push(10'(10'h200 + 37 * i));
        for (int c = 0; c < 80 && (n_got - base_got) < 9; c++) begin
            bus.ready_in = c[0];
            #1;
            hold = bus.valid_out && !bus.ready_in;
            held = bus.data_out;
            @(negedge clk);
            if (hold) begin
                checks++;
                if (bus.data_out !== held) begin failures++; $display("FAIL wrap_hold: got %h expected %h", bus.data_out, held); end
            end
        end
        bus.ready_in = 1'b1;
        checks++; if (n_got - base_got != 9) begin failures++; $display("FAIL wrap_count: got %0d expected 9", n_got - base_got); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[base_got + i] !== 10'(10'h200 + 37 * i)) begin
                failures++;
                $display("FAIL wrap_word%0d: got %h expected %h", i, got[base_got + i], 10'(10'h200 + 37 * i));
            end
        end
        repeat (2) @(negedge clk);
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL wrap_idle: got %0d expected %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_fault();
        int base_rd;
        int base_got;
        base_got = n_got;
        bus.ready_in = 1'b0;
        push(10'h0AA);
        push(10'h3C3);
        repeat (5) @(negedge clk);
        checks++; if (dut.occ !== 3'd2) begin failures++; $display("FAIL fault_pre_occ: got %0d expected 2", dut.occ); end
        bus.fifo_error = 1'b1;
        @(negedge clk);
        bus.fifo_error = 1'b0;
        checks++; if (bus.reader_err !== 1'b1) begin failures++; $display("FAIL fault_err_rise: got %b expected 1", bus.reader_err); end
        checks++; if (dut.state_q !== FAULT) begin failures++; $display("FAIL fault_state: got %0d expected %0d", dut.state_q, FAULT); end
        base_rd = rd_pulses;
        push(10'h111);
        push(10'h222);
        #1;
        checks++; if (bus.fifo_rd !== 1'b0) begin failures++; $display("FAIL fault_no_rd: got %b expected 0", bus.fifo_rd); end
        bus.ready_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (n_got - base_got != 2) begin failures++; $display("FAIL fault_drain_count: got %0d expected 2", n_got - base_got); end
        checks++; if (got[base_got] !== 10'h0AA) begin failures++; $display("FAIL fault_drain0: got %h expected 0aa", got[base_got]); end
        checks++; if (got[base_got + 1] !== 10'h3C3) begin failures++; $display("FAIL fault_drain1: got %h expected 3c3", got[base_got + 1]); end
        checks++; if (rd_pulses - base_rd != 0) begin failures++; $display("FAIL fault_pulses: got %0d expected 0", rd_pulses - base_rd); end
        bus.fifo_error = 1'b1;
        bus.err_clr    = 1'b1;
        @(negedge clk);
        bus.fifo_error = 1'b0;
        checks++; if (dut.state_q !== FAULT) begin failures++; $display("FAIL fault_precedence: got %0d expected %0d", dut.state_q, FAULT); end
        checks++; if (bus.reader_err !== 1'b1) begin failures++; $display("FAIL fault_err_held: got %b expected 1", bus.reader_err); end
        @(negedge clk);
        bus.err_clr = 1'b0;
        checks++; if (bus.reader_err !== 1'b0) begin failures++; $display("FAIL fault_err_fall: got %b expected 0", bus.reader_err); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL fault_clr_idle: got %0d expected %0d", dut.state_q, IDLE); end
        for (int c = 0; c < 12 && (n_got - base_got) < 4; c++) @(negedge clk);
        checks++; if (n_got - base_got != 4) begin failures++; $display("FAIL fault_resume_count: got %0d expected 4", n_got - base_got); end
        checks++; if (got[base_got + 2] !== 10'h111) begin failures++; $display("FAIL fault_resume0: got %h expected 111", got[base_got + 2]); end
        checks++; if (got[base_got + 3] !== 10'h222) begin failures++; $display("FAIL fault_resume1: got %h expected 222", got[base_got + 3]); end
    endtask

    task automatic test_async_reset();
        int base_rd;
        int base_got;
        base_got = n_got;
        bus.ready_in = 1'b0;
        push(10'h0F1);
        push(10'h0F2);
        push(10'h0F3);
        for (int c = 0; c < 12 && !(dut.occ == 3'd3 && !dut.inflight && bus.fifo_empty); c++) @(negedge clk);
        checks++; if (dut.occ !== 3'd3) begin failures++; $display("FAIL arst_pre_occ: got %0d expected 3", dut.occ); end
`ifdef FIFO_READ_CTRL_STATS_EN
        checks++; if (rd_count !== 16'd20) begin failures++; $display("FAIL arst_pre_count: got %0d expected 20", rd_count); end
`endif
        push(10'h0F4);
        push(10'h0F5);
        #1;
        checks++; if (bus.fifo_rd !== 1'b1) begin failures++; $display("FAIL arst_pre_rd: got %b expected 1", bus.fifo_rd); end
        checks++; if (bus.valid_out !== 1'b1) begin failures++; $display("FAIL arst_pre_valid: got %b expected 1", bus.valid_out); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (bus.fifo_rd !== 1'b0) begin failures++; $display("FAIL arst_rd_drop: got %b expected 0", bus.fifo_rd); end
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL arst_valid_drop: got %b expected 0", bus.valid_out); end
        checks++; if (bus.data_out !== 10'h000) begin failures++; $display("FAIL arst_data: got %h expected 000", bus.data_out); end
`ifdef FIFO_READ_CTRL_STATS_EN
        checks++; if (rd_count !== 16'd0) begin failures++; $display("FAIL arst_count: got %0d expected 0", rd_count); end
`endif
        bus.rd_en    = 1'b0;
        bus.ready_in = 1'b1;
        base_rd = rd_pulses;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (n_got - base_got != 0) begin failures++; $display("FAIL arst_no_emit: got %0d expected 0", n_got - base_got); end
        checks++; if (bus.valid_out !== 1'b0) begin failures++; $display("FAIL arst_valid_idle: got %b expected 0", bus.valid_out); end
        checks++; if (rd_pulses - base_rd != 0) begin failures++; $display("FAIL arst_no_rd: got %0d expected 0", rd_pulses - base_rd); end
        bus.rd_en = 1'b1;
        for (int c = 0; c < 12 && (n_got - base_got) < 2; c++) @(negedge clk);
        checks++; if (n_got - base_got != 2) begin failures++; $display("FAIL arst_resume_count: got %0d expected 2", n_got - base_got); end
        checks++; if (got[base_got] !== 10'h0F4) begin failures++; $display("FAIL arst_resume0: got %h expected 0f4", got[base_got]); end
        checks++; if (got[base_got + 1] !== 10'h0F5) begin failures++; $display("FAIL arst_resume1: got %h expected 0f5", got[base_got + 1]); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_pressure();
        test_wrap();
        test_fault();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the project FIFO. It watches the FIFO's `fifo_empty` and `error` flags and issues `fifo_rd` strobes. It captures the word returned one cycle later into a 4-entry ring buffer and presents the words to a downstream consumer over a valid/ready handshake. It sits between the FIFO memory/control pair and the consumer, and is the read-direction counterpart of the write path that drives `fifo_wr`.

## Interface
- `WORD_SIZE`, default 10: bits per data word; must match the FIFO word width.
- `CNT_W`, default 16: width of the pop statistics counter (used only with the macro).
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `rd_en`, input, 1: system enable for reads. When 0, no new `fifo_rd` is issued.
- `fifo_empty`, input, 1: empty flag from the FIFO control logic.
- `fifo_error`, input, 1: error flag from the FIFO control logic.
- `fifo_data`, input, `WORD_SIZE`: FIFO read data, valid the cycle after `fifo_rd`.
- `fifo_rd`, output, 1: FIFO read strobe.
- `data_out`, output, `WORD_SIZE`: head-of-buffer word.
- `valid_out`, output, 1: `data_out` is valid.
- `ready_in`, input, 1: consumer accepts `data_out` this cycle.
- `err_clr`, input, 1: clears the fault state.
- `reader_err`, output, 1: sticky fault indication.
- `rd_count`, output, `CNT_W`: number of words popped. Present only with `FIFO_READ_CTRL_STATS_EN`.

## Operation
- Internal state:
  - `occ`: buffer occupancy, 0..4, 3 bits.
  - `inflight`: 1-bit flop equal to `fifo_rd` delayed by one cycle.
  - `wr_ptr` and `rd_ptr`: 2 bits each; they wrap naturally from 3 to 0.
- Read strobe:
  - `fifo_rd = rd_en & ~fifo_empty & ~reset & (state != FAULT) & (occ + inflight < 4)`.
  - The occupancy term guarantees that a returning word always has a free slot.
- Capture: when `inflight` = 1, `fifo_data` is written at `wr_ptr` and `wr_ptr` increments.
- Pop: `pop = valid_out & ready_in`; on a pop, `rd_ptr` increments.
- Occupancy update: `occ_next = occ + inflight - pop`. Simultaneous capture and pop leave `occ` unchanged.
- Outputs: `valid_out = (occ != 0)` and `data_out = buf[rd_ptr]`. `data_out` is held stable while `valid_out & ~ready_in`.
- State machine:
  - IDLE: `occ` = 0 and `inflight` = 0.
    - Goes to RUN on `fifo_rd`.
  - RUN: data is outstanding or buffered.
    - Goes to STALL when `occ_next` = 4.
    - Goes to IDLE when `occ_next` = 0 and `fifo_rd` = 0.
  - STALL: buffer full and `fifo_rd` forced to 0.
    - Goes to RUN on the first pop.
  - FAULT: entered from any state when `fifo_error` = 1 at a clock edge.
    - `reader_err` = 1 and `fifo_rd` = 0.
    - An in-flight word is still captured, and the buffer keeps draining to the consumer.
    - On `err_clr`: goes to IDLE if `occ_next` = 0, otherwise to RUN.
- Precedence: `fifo_error` has priority over `err_clr` in the same cycle, so the block stays in FAULT.
- `rd_en` dropping mid-operation: no new reads are issued, and buffered and in-flight words still drain.

## Timing
- Reset values: state IDLE, `occ` 0, pointers 0, `inflight` 0, `valid_out` 0, `data_out` 0, `reader_err` 0, `rd_count` 0.
- `fifo_rd` is forced low asynchronously while `reset` = 1.
- Latency:
  - `fifo_rd` at edge N, the word is captured at N+1.
  - `valid_out` rises in the cycle after N+1, so the first word is visible 2 cycles after `fifo_rd`.
- Throughput: one word per cycle sustained while `ready_in` = 1 and the FIFO is non-empty. There is no combinational path from `ready_in` to `fifo_rd`.
- `reader_err` rises the cycle after `fifo_error` is sampled. It falls the cycle after `err_clr` is sampled.
- Reset mid-operation discards buffer contents and any in-flight word.

## Configuration
- Macro: `FIFO_READ_CTRL_STATS_EN`.
- Defined:
  - `rd_count` exists and increments on every pop.
  - It saturates at 2^`CNT_W`-1 and clears only on reset.
- Undefined: the `rd_count` port and its counter are absent; all other behaviour is identical.

## Structure
- Package `fifo_read_ctrl_pkg` holds:
  - the state enum (IDLE, RUN, STALL, FAULT), 2-bit encoding;
  - the `BUF_DEPTH` = 4 constant;
  - the pointer width constant (2).
- Sub-module `read_ring_buf` is the 4-entry storage with `wr_ptr`/`rd_ptr`, capture, pop and `occ`.
- `fifo_read_ctrl` keeps the FSM, `fifo_rd` generation and the statistics counter.

## Test plan
- Single word:
  - Stimulus: FIFO holds 0x155, `rd_en` = 1, `ready_in` = 1.
  - Required: `fifo_rd` pulses for 1 cycle; `data_out` = 0x155 with `valid_out` 2 cycles later; state returns to IDLE.
- Back-pressure:
  - Stimulus: 6 words queued, `ready_in` = 0.
  - Required: exactly 4 `fifo_rd` pulses, STALL with `occ` = 4, `fifo_rd` = 0.
  - Then `ready_in` = 1: all 6 words arrive in order, one per cycle after refill.
- Pointer wrap: 9 words streamed with `ready_in` toggling every cycle → output order is preserved across two pointer wraps.
- Fault:
  - Stimulus: `fifo_error` = 1 with 2 words buffered.
  - Required: `reader_err` = 1 the next cycle; no `fifo_rd`; the 2 words still drain.
  - `err_clr` → IDLE, and reading resumes.
- Asynchronous reset mid-stream:
  - Stimulus: `reset` asserted between edges with `occ` = 3.
  - Required: `fifo_rd` and `valid_out` drop immediately; `rd_count` = 0; no word is emitted after release until a new `fifo_rd`.
